// File: rtl/axi4lite_wb_demux.sv
// AXI4-Lite slave to multi-port Wishbone master bridge.
// One transaction in flight; the address selects one of NUM_SLAVES Wishbone
// ports, and undecodable addresses, bus errors and timeouts become AXI errors.
module axi4lite_wb_demux #(
    parameter int C_AXI_DATA_WIDTH = 32,
    parameter int C_AXI_ADDR_WIDTH = 32,
    parameter int NUM_SLAVES       = 4,
    parameter int SLAVE_AW         = 12,
    parameter int TIMEOUT_CYCLES   = 255
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    // write address
    output logic                                   o_axi_awready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]            i_axi_awaddr,
    input  logic [3:0]                             i_axi_awcache,
    input  logic [2:0]                             i_axi_awprot,
    input  logic                                   i_axi_awvalid,
    // write data
    output logic                                   o_axi_wready,
    input  logic [C_AXI_DATA_WIDTH-1:0]            i_axi_wdata,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]          i_axi_wstrb,
    input  logic                                   i_axi_wvalid,
    // write response
    output logic [1:0]                             o_axi_bresp,
    output logic                                   o_axi_bvalid,
    input  logic                                   i_axi_bready,
    // read address
    output logic                                   o_axi_arready,
    input  logic [C_AXI_ADDR_WIDTH-1:0]            i_axi_araddr,
    input  logic [3:0]                             i_axi_arcache,
    input  logic [2:0]                             i_axi_arprot,
    input  logic                                   i_axi_arvalid,
    // read data
    output logic [1:0]                             o_axi_rresp,
    output logic                                   o_axi_rvalid,
    output logic [C_AXI_DATA_WIDTH-1:0]            o_axi_rdata,
    input  logic                                   i_axi_rready,
    // wishbone
    output logic [NUM_SLAVES-1:0]                  o_wb_cyc,
    output logic [NUM_SLAVES-1:0]                  o_wb_stb,
    output logic                                   o_wb_we,
    output logic [SLAVE_AW-3:0]                    o_wb_addr,
    output logic [C_AXI_DATA_WIDTH-1:0]            o_wb_data,
    output logic [C_AXI_DATA_WIDTH/8-1:0]          o_wb_sel,
    input  logic [NUM_SLAVES*C_AXI_DATA_WIDTH-1:0] i_wb_data,
    input  logic [NUM_SLAVES-1:0]                  i_wb_ack,
    input  logic [NUM_SLAVES-1:0]                  i_wb_err
);

    localparam int DW = C_AXI_DATA_WIDTH;
    localparam int IW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {IDLE, BUS, WRESP, RRESP} state_t;

    state_t                state;
    logic                  is_wr;
    logic                  prefer_rd;   // type that was not served last
    logic [TW-1:0]         tcnt;

    logic                  wr_pend;
    logic                  rd_go;
    logic                  wr_go;
    logic [C_AXI_ADDR_WIDTH-1:0] req_addr;
    logic [IW-1:0]         idx;
    logic                  hi_bits;
    logic                  dec_err;
    logic [NUM_SLAVES-1:0] dec_onehot;
    logic                  bus_ack;
    logic                  bus_err;
    logic                  timeout_hit;
    logic [DW-1:0]         bus_data;
    logic                  unused_ok;

    // Grant in IDLE only; the type served last yields when both are pending.
    assign wr_pend       = i_axi_awvalid && i_axi_wvalid;
    assign rd_go         = (state == IDLE) && i_axi_arvalid && (!wr_pend || prefer_rd);
    assign wr_go         = (state == IDLE) && wr_pend && (!i_axi_arvalid || !prefer_rd);
    assign o_axi_arready = rd_go;
    assign o_axi_awready = wr_go;
    assign o_axi_wready  = wr_go;

    assign req_addr = wr_go ? i_axi_awaddr : i_axi_araddr;
    assign idx      = req_addr[SLAVE_AW+IW-1:SLAVE_AW];
    assign hi_bits  = (req_addr >> (SLAVE_AW + IW)) != '0;
    assign dec_err  = hi_bits || (int'(idx) >= NUM_SLAVES);

    // Only the port currently strobed may end the cycle.
    assign bus_ack     = |(i_wb_ack & o_wb_stb);
    assign bus_err     = |(i_wb_err & o_wb_stb);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt == TW'(TIMEOUT_CYCLES - 1));

    assign unused_ok = ^{i_axi_awcache, i_axi_awprot, i_axi_arcache, i_axi_arprot,
                         req_addr[1:0]};

    // Address decode to a one-hot port select.
    always_comb begin
        dec_onehot = '0;
        for (int n = 0; n < NUM_SLAVES; n++)
            dec_onehot[n] = (idx == IW'(n));
    end

    // Read-data mux driven by the active strobe.
    always_comb begin
        bus_data = '0;
        for (int n = 0; n < NUM_SLAVES; n++)
            if (o_wb_stb[n])
                bus_data = i_wb_data[n*DW +: DW];
    end

    // Transaction FSM with registered Wishbone and AXI response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= IDLE;
            is_wr        <= 1'b0;
            prefer_rd    <= 1'b1;
            tcnt         <= '0;
            o_wb_cyc     <= '0;
            o_wb_stb     <= '0;
            o_wb_we      <= 1'b0;
            o_wb_addr    <= '0;
            o_wb_data    <= '0;
            o_wb_sel     <= '0;
            o_axi_bvalid <= 1'b0;
            o_axi_bresp  <= RESP_OKAY;
            o_axi_rvalid <= 1'b0;
            o_axi_rresp  <= RESP_OKAY;
            o_axi_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_go || wr_go) begin
                        is_wr     <= wr_go;
                        prefer_rd <= wr_go;
                        o_wb_we   <= wr_go;
                        o_wb_addr <= req_addr[SLAVE_AW-1:2];
                        o_wb_data <= i_axi_wdata;
                        o_wb_sel  <= wr_go ? i_axi_wstrb : '1;
                        tcnt      <= '0;
                        if (dec_err) begin
                            // No Wishbone cycle for an unmapped address.
                            if (wr_go) begin
                                o_axi_bvalid <= 1'b1;
                                o_axi_bresp  <= RESP_DECERR;
                                state        <= WRESP;
                            end else begin
                                o_axi_rvalid <= 1'b1;
                                o_axi_rresp  <= RESP_DECERR;
                                o_axi_rdata  <= '0;
                                state        <= RRESP;
                            end
                        end else begin
                            o_wb_cyc <= dec_onehot;
                            o_wb_stb <= dec_onehot;
                            state    <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (bus_err || bus_ack || timeout_hit) begin
                        o_wb_cyc <= '0;
                        o_wb_stb <= '0;
                        if (is_wr) begin
                            o_axi_bvalid <= 1'b1;
                            o_axi_bresp  <= (bus_ack && !bus_err) ? RESP_OKAY : RESP_SLVERR;
                            state        <= WRESP;
                        end else begin
                            o_axi_rvalid <= 1'b1;
                            o_axi_rresp  <= (bus_ack && !bus_err) ? RESP_OKAY : RESP_SLVERR;
                            o_axi_rdata  <= (bus_ack && !bus_err) ? bus_data : '0;
                            state        <= RRESP;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                WRESP: begin
                    if (i_axi_bready) begin
                        o_axi_bvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                RRESP: begin
                    if (i_axi_rready) begin
                        o_axi_rvalid <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
